// File: rtl/dbf_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dbf_seq_pkg : shared types and constants for the DBF scan sequencer
// rev 1.0
// ----------------------------------------------------------------------------
package dbf_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LINE_INIT = 3'd1,
        ACQ       = 3'd2,
        LINE_END  = 3'd3,
        WAIT_TX   = 3'd4
    } state_t;

    // Wide enough for any practical ADDR_WD; users truncate to their width.
    localparam logic [63:0] LUT_IDLE_ADDR = '1;

endpackage
`default_nettype wire

// File: rtl/dbf_scan_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dbf_scan_sequencer_if : control, config and LUT-address bundle of the sequencer
// rev 1.0
// ----------------------------------------------------------------------------
interface dbf_scan_sequencer_if #(
    parameter int ADDR_WD = 12,
    parameter int LINE_WD = 8,
    parameter int SCNT_WD = 20
) ();
    logic               enable;
    logic               tx_en;
    logic [LINE_WD-1:0] cfg_num_lines;
    logic [SCNT_WD-1:0] cfg_nf_samples;
    logic               cfg_single;
    logic               dbf_start;
    logic [ADDR_WD-1:0] lut_addr;
    logic               lut_addr_vld;
    logic [LINE_WD-1:0] line_idx;
    logic               frame_start;
    logic               frame_end;
    logic               busy;
    logic               overrun;

    modport slave (
        input  enable, tx_en, cfg_num_lines, cfg_nf_samples, cfg_single,
        output dbf_start, lut_addr, lut_addr_vld, line_idx,
               frame_start, frame_end, busy, overrun
    );

    modport master (
        output enable, tx_en, cfg_num_lines, cfg_nf_samples, cfg_single,
        input  dbf_start, lut_addr, lut_addr_vld, line_idx,
               frame_start, frame_end, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/dbf_zone_addr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dbf_zone_addr : delay-LUT address {line_idx, zone} with zone saturation and nf gate
// rev 1.0
// ----------------------------------------------------------------------------
module dbf_zone_addr #(
    parameter int ADDR_WD    = 12,
    parameter int LINE_WD    = 8,
    parameter int ZONE_WD    = 6,
    parameter int ZONE_SHIFT = 6,
    parameter int SCNT_WD    = 20
) (
    input  logic [LINE_WD-1:0] line_idx,
    input  logic [SCNT_WD-1:0] sample_cnt,
    input  logic [SCNT_WD-1:0] nf,
    output logic [ADDR_WD-1:0] addr,
    output logic               load
);
    localparam logic [SCNT_WD-1:0] ZONE_MAX = SCNT_WD'((1 << ZONE_WD) - 1);

    logic [SCNT_WD-1:0] zone_raw;
    logic [ZONE_WD-1:0] zone;

    // nf == 0 pins the whole line to zone 0 instead of leaving the address stale.
    always_comb begin
        zone_raw = sample_cnt >> ZONE_SHIFT;
        if (nf == '0)
            zone = '0;
        else if (zone_raw > ZONE_MAX)
            zone = ZONE_MAX[ZONE_WD-1:0];
        else
            zone = zone_raw[ZONE_WD-1:0];
        load = (nf == '0) || (sample_cnt < nf);
        addr = ADDR_WD'({line_idx, zone});
    end
endmodule
`default_nettype wire

// File: rtl/dbf_scan_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dbf_scan_sequencer : DBF receive line/frame sequencer driven by tx_en falling edges
// rev 1.0
// ----------------------------------------------------------------------------
module dbf_scan_sequencer
    import dbf_seq_pkg::*;
#(
    parameter int ADDR_WD    = 12,
    parameter int LINE_WD    = 8,
    parameter int ZONE_WD    = 6,
    parameter int ZONE_SHIFT = 6,
    parameter int SCNT_WD    = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    dbf_scan_sequencer_if.slave  bus
);
    generate
        if (LINE_WD + ZONE_WD > ADDR_WD) begin : g_param_check
            $error("LINE_WD + ZONE_WD exceeds ADDR_WD");
        end
    endgenerate

    localparam logic [ADDR_WD-1:0] IDLE_ADDR = ADDR_WD'(LUT_IDLE_ADDR);

    state_t             state;
    logic               tx_q;
    logic               first_line;
    logic               single_done;
    logic               sh_single;
    logic [LINE_WD-1:0] sh_nl;
    logic [SCNT_WD-1:0] sh_nf;
    logic [SCNT_WD-1:0] sample_cnt;

    logic [LINE_WD-1:0] nl_eff;
    logic               last_line;
    logic               rx_start;
    logic               zone_load;
    logic [ADDR_WD-1:0] zone_addr;

    assign rx_start  = tx_q & ~bus.tx_en;
    assign nl_eff    = (sh_nl == '0) ? LINE_WD'(1) : sh_nl;
    assign last_line = (bus.line_idx == nl_eff - LINE_WD'(1));

    dbf_zone_addr #(
        .ADDR_WD    (ADDR_WD),
        .LINE_WD    (LINE_WD),
        .ZONE_WD    (ZONE_WD),
        .ZONE_SHIFT (ZONE_SHIFT),
        .SCNT_WD    (SCNT_WD)
    ) u_zone_addr (
        .line_idx   (bus.line_idx),
        .sample_cnt (sample_cnt),
        .nf         (sh_nf),
        .addr       (zone_addr),
        .load       (zone_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            tx_q             <= 1'b0;
            first_line       <= 1'b1;
            single_done      <= 1'b0;
            sh_single        <= 1'b0;
            sh_nl            <= '0;
            sh_nf            <= '0;
            sample_cnt       <= '0;
            bus.dbf_start    <= 1'b0;
            bus.lut_addr     <= IDLE_ADDR;
            bus.lut_addr_vld <= 1'b0;
            bus.line_idx     <= '0;
            bus.frame_start  <= 1'b0;
            bus.frame_end    <= 1'b0;
            bus.busy         <= 1'b0;
            bus.overrun      <= 1'b0;
        end else begin
            tx_q            <= bus.tx_en;
            bus.frame_start <= 1'b0;
            bus.frame_end   <= 1'b0;
            bus.overrun     <= 1'b0;
            if (!bus.enable) begin
                state            <= IDLE;
                first_line       <= 1'b1;
                single_done      <= 1'b0;
                sample_cnt       <= '0;
                bus.dbf_start    <= 1'b0;
                bus.lut_addr_vld <= 1'b0;
                bus.lut_addr     <= IDLE_ADDR;
                bus.busy         <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        bus.dbf_start    <= 1'b0;
                        bus.lut_addr_vld <= 1'b0;
                        bus.lut_addr     <= IDLE_ADDR;
                        // A finished single frame stays parked until cfg_single drops or enable cycles.
                        if (rx_start && !(single_done && bus.cfg_single)) begin
                            state       <= LINE_INIT;
                            single_done <= 1'b0;
                            bus.busy    <= 1'b1;
                        end
                    end
                    LINE_INIT: begin
                        if (first_line || last_line) begin
                            bus.line_idx    <= '0;
                            bus.frame_start <= 1'b1;
                            sh_nl           <= bus.cfg_num_lines;
                            sh_nf           <= bus.cfg_nf_samples;
                            sh_single       <= bus.cfg_single;
                        end else begin
                            bus.line_idx <= bus.line_idx + LINE_WD'(1);
                        end
                        sample_cnt    <= '0;
                        bus.dbf_start <= 1'b1;
                        first_line    <= 1'b0;
                        if (bus.tx_en) begin
                            bus.overrun <= 1'b1;
                            state       <= LINE_END;
                        end else begin
                            state <= ACQ;
                        end
                    end
                    ACQ: begin
                        bus.dbf_start    <= 1'b1;
                        bus.lut_addr_vld <= 1'b1;
                        if (sample_cnt != '1)
                            sample_cnt <= sample_cnt + SCNT_WD'(1);
                        if (zone_load)
                            bus.lut_addr <= zone_addr;
                        if (bus.tx_en)
                            state <= LINE_END;
                    end
                    LINE_END: begin
                        bus.dbf_start    <= 1'b0;
                        bus.lut_addr_vld <= 1'b0;
                        bus.lut_addr     <= '0;
                        bus.frame_end    <= last_line;
                        if (sh_single && last_line) begin
                            state       <= IDLE;
                            first_line  <= 1'b1;
                            single_done <= 1'b1;
                            bus.busy    <= 1'b0;
                        end else begin
                            state <= WAIT_TX;
                        end
                    end
                    WAIT_TX: begin
                        bus.dbf_start    <= 1'b0;
                        bus.lut_addr_vld <= 1'b0;
                        bus.lut_addr     <= IDLE_ADDR;
                        if (!bus.tx_en)
                            state <= LINE_INIT;
                    end
                    default: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dbf_scan_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dbf_scan_sequencer : directed table-driven bench for dbf_scan_sequencer
// rev 1.0
// ----------------------------------------------------------------------------
module tb_dbf_scan_sequencer;
    localparam int ADDR_WD = 12;
    localparam int LINE_WD = 8;
    localparam int SCNT_WD = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    dbf_scan_sequencer_if #(.ADDR_WD(ADDR_WD), .LINE_WD(LINE_WD), .SCNT_WD(SCNT_WD)) bus ();

    dbf_scan_sequencer #(
        .ADDR_WD(ADDR_WD), .LINE_WD(LINE_WD), .ZONE_WD(6), .ZONE_SHIFT(6), .SCNT_WD(SCNT_WD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tx;
        logic        en;
        logic        dbf;
        logic        vld;
        logic [7:0]  line;
        logic [11:0] addr;
        logic        fs;
        logic        fe;
        logic        busy;
        logic        ov;
    } vec_t;

    vec_t vt[22];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One complete receive line: falling tx_en, nacq ACQ cycles, rising tx_en, LINE_END.
    task automatic do_line(input int nacq, output logic [7:0] line, output logic fs,
                           output logic fe, output logic bsy);
        bus.tx_en = 1'b0;
        step();
        step();
        line = bus.line_idx;
        fs   = bus.frame_start;
        repeat (nacq) step();
        bus.tx_en = 1'b1;
        step();
        step();
        fe  = bus.frame_end;
        bsy = bus.busy;
    endtask

    initial begin
        logic [7:0] ln;
        logic       fs, fe, bsy;
        logic [7:0] exp_ln[8];
        logic       exp_fs[8];
        logic       exp_fe[8];

        bus.enable         = 1'b0;
        bus.tx_en          = 1'b0;
        bus.cfg_num_lines  = 8'd3;
        bus.cfg_nf_samples = 20'd200;
        bus.cfg_single     = 1'b0;

        //          tx en dbf vld line addr   fs fe busy ov
        vt[0]  = '{1, 1, 0, 0, 0, 12'hFFF, 0, 0, 0, 0};
        vt[1]  = '{0, 1, 0, 0, 0, 12'hFFF, 0, 0, 1, 0};
        vt[2]  = '{0, 1, 1, 0, 0, 12'hFFF, 1, 0, 1, 0};
        vt[3]  = '{0, 1, 1, 1, 0, 12'd0,   0, 0, 1, 0};
        vt[4]  = '{1, 1, 1, 1, 0, 12'd0,   0, 0, 1, 0};
        vt[5]  = '{1, 1, 0, 0, 0, 12'd0,   0, 0, 1, 0};
        vt[6]  = '{0, 1, 0, 0, 0, 12'hFFF, 0, 0, 1, 0};
        vt[7]  = '{0, 1, 1, 0, 1, 12'hFFF, 0, 0, 1, 0};
        vt[8]  = '{1, 1, 1, 1, 1, 12'd64,  0, 0, 1, 0};
        vt[9]  = '{1, 1, 0, 0, 1, 12'd0,   0, 0, 1, 0};
        vt[10] = '{0, 1, 0, 0, 1, 12'hFFF, 0, 0, 1, 0};
        vt[11] = '{0, 1, 1, 0, 2, 12'hFFF, 0, 0, 1, 0};
        vt[12] = '{1, 1, 1, 1, 2, 12'd128, 0, 0, 1, 0};
        vt[13] = '{1, 1, 0, 0, 2, 12'd0,   0, 1, 1, 0};
        vt[14] = '{0, 1, 0, 0, 2, 12'hFFF, 0, 0, 1, 0};
        vt[15] = '{0, 1, 1, 0, 0, 12'hFFF, 1, 0, 1, 0};
        vt[16] = '{1, 1, 1, 1, 0, 12'd0,   0, 0, 1, 0};
        vt[17] = '{1, 1, 0, 0, 0, 12'd0,   0, 0, 1, 0};
        vt[18] = '{0, 1, 0, 0, 0, 12'hFFF, 0, 0, 1, 0};
        vt[19] = '{1, 1, 1, 0, 1, 12'hFFF, 0, 0, 1, 1};
        vt[20] = '{1, 1, 0, 0, 1, 12'd0,   0, 0, 1, 0};
        vt[21] = '{1, 1, 0, 0, 1, 12'hFFF, 0, 0, 1, 0};

        // Reset values
        step();
        step();
        chk("rst_lut_addr", bus.lut_addr, 32'hFFF);
        chk("rst_line_idx", bus.line_idx, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_dbf_start", bus.dbf_start, 0);
        chk("rst_vld", bus.lut_addr_vld, 0);
        rst = 1'b0;

        // Three-line frame with wrap, then an overrun line
        for (int i = 0; i < 22; i++) begin
            bus.tx_en  = vt[i].tx;
            bus.enable = vt[i].en;
            step();
            chk($sformatf("v%0d_dbf_start", i), bus.dbf_start, vt[i].dbf);
            chk($sformatf("v%0d_vld", i), bus.lut_addr_vld, vt[i].vld);
            chk($sformatf("v%0d_line_idx", i), bus.line_idx, vt[i].line);
            chk($sformatf("v%0d_lut_addr", i), bus.lut_addr, vt[i].addr);
            chk($sformatf("v%0d_frame_start", i), bus.frame_start, vt[i].fs);
            chk($sformatf("v%0d_frame_end", i), bus.frame_end, vt[i].fe);
            chk($sformatf("v%0d_busy", i), bus.busy, vt[i].busy);
            chk($sformatf("v%0d_overrun", i), bus.overrun, vt[i].ov);
        end

        // Zone addressing on line 2, nf = 200
        bus.tx_en = 1'b0;
        step();
        step();
        chk("zone_line_idx", bus.line_idx, 2);
        for (int k = 0; k <= 260; k++) begin
            step();
            if (k == 0 || k == 63)
                chk($sformatf("zone_s%0d", k), bus.lut_addr, 128);
            if (k == 64)
                chk($sformatf("zone_s%0d", k), bus.lut_addr, 129);
            if (k == 128)
                chk($sformatf("zone_s%0d", k), bus.lut_addr, 130);
            if (k == 192 || k == 199 || k == 200 || k == 260)
                chk($sformatf("zone_s%0d", k), bus.lut_addr, 131);
        end
        bus.tx_en = 1'b1;
        step();
        chk("zone_hold_at_tx", bus.lut_addr, 131);
        step();
        chk("zone_line_end_addr", bus.lut_addr, 0);
        chk("zone_frame_end", bus.frame_end, 1);

        // Line-count change mid-frame takes effect at next frame start
        exp_ln = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
        exp_fs = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_fe = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            do_line(3, ln, fs, fe, bsy);
            if (i == 0) bus.cfg_num_lines = 8'd5;
            chk($sformatf("nl_l%0d_line_idx", i), ln, exp_ln[i]);
            chk($sformatf("nl_l%0d_frame_start", i), fs, exp_fs[i]);
            chk($sformatf("nl_l%0d_frame_end", i), fe, exp_fe[i]);
        end

        // Single-frame mode, two lines, then a third pulse is ignored
        bus.cfg_single    = 1'b1;
        bus.cfg_num_lines = 8'd2;
        do_line(2, ln, fs, fe, bsy);
        chk("single_l0_line_idx", ln, 0);
        chk("single_l0_frame_start", fs, 1);
        chk("single_l0_busy", bsy, 1);
        do_line(2, ln, fs, fe, bsy);
        chk("single_l1_line_idx", ln, 1);
        chk("single_l1_frame_end", fe, 1);
        chk("single_l1_busy", bsy, 0);
        bus.tx_en = 1'b0;
        step();
        step();
        chk("single_ignored_busy", bus.busy, 0);
        chk("single_ignored_dbf", bus.dbf_start, 0);
        bus.tx_en = 1'b1;
        step();

        // Enable dropped mid-ACQ of line 5
        bus.cfg_single    = 1'b0;
        bus.cfg_num_lines = 8'd8;
        for (int i = 0; i < 5; i++) begin
            do_line(1, ln, fs, fe, bsy);
            chk($sformatf("abort_l%0d_line_idx", i), ln, i);
        end
        bus.tx_en = 1'b0;
        step();
        step();
        chk("abort_line5_idx", bus.line_idx, 5);
        step();
        step();
        chk("abort_acq_vld", bus.lut_addr_vld, 1);
        bus.enable = 1'b0;
        step();
        chk("abort_busy", bus.busy, 0);
        chk("abort_dbf", bus.dbf_start, 0);
        chk("abort_vld", bus.lut_addr_vld, 0);
        chk("abort_lut_addr", bus.lut_addr, 32'hFFF);
        bus.enable = 1'b1;
        step();
        bus.tx_en = 1'b1;
        step();
        bus.tx_en = 1'b0;
        step();
        chk("reen_busy", bus.busy, 1);
        step();
        chk("reen_line_idx", bus.line_idx, 0);
        chk("reen_frame_start", bus.frame_start, 1);
        chk("reen_dbf", bus.dbf_start, 1);

        // Asynchronous reset mid-line
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_dbf", bus.dbf_start, 0);
        chk("arst_vld", bus.lut_addr_vld, 0);
        chk("arst_lut_addr", bus.lut_addr, 32'hFFF);
        step();
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
